// File: rtl/mem_port_requester_if.sv
// Signal bundle between a cache controller, mem_port_requester and its memory-bus port.
// master = the requester block itself; slave = whatever drives it (controller + responder).
interface mem_port_requester_if #(
    parameter int DATA_SIZE = 2,
    parameter int ADDR_W    = 14
);
    logic                   core_req_valid;
    logic                   core_req_ready;
    logic                   core_req_we;
    logic [ADDR_W-1:0]      core_req_addr;
    logic [DATA_SIZE*8-1:0] core_req_wdata;
    logic                   core_rsp_valid;
    logic                   core_rsp_ready;
    logic                   core_rsp_we;
    logic [DATA_SIZE*8-1:0] core_rsp_rdata;
    logic                   core_rsp_err;
    logic                   processor_req;
    logic                   mem_read_req;
    logic                   mem_write_req;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_SIZE*8-1:0] mem_write_data;
    logic [DATA_SIZE*8-1:0] mem_read_data;
    logic                   processor_resp;
    logic                   busy;

    modport master (
        input  core_req_valid, core_req_we, core_req_addr, core_req_wdata,
        input  core_rsp_ready, mem_read_data, processor_resp,
        output core_req_ready, core_rsp_valid, core_rsp_we, core_rsp_rdata, core_rsp_err,
        output processor_req, mem_read_req, mem_write_req, addr, mem_write_data, busy
    );

    modport slave (
        output core_req_valid, core_req_we, core_req_addr, core_req_wdata,
        output core_rsp_ready, mem_read_data, processor_resp,
        input  core_req_ready, core_rsp_valid, core_rsp_we, core_rsp_rdata, core_rsp_err,
        input  processor_req, mem_read_req, mem_write_req, addr, mem_write_data, busy
    );
endinterface

// File: rtl/mem_port_requester.sv
// Buffers load/store commands in a small FIFO and issues them one at a time on the
// shared memory bus, returning a completion (or a timeout error) to the cache controller.
module mem_port_requester #(
    parameter int DATA_SIZE  = 2,
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32
) (
    input logic clk,
    input logic reset,
    mem_port_requester_if.master bus
);
    localparam int DW = DATA_SIZE * 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TLAST_C = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic              fifo_we    [FIFO_DEPTH];
    logic [DW-1:0]     fifo_wdata [FIFO_DEPTH];

    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              cmd_we_q, cmd_we_d;
    logic [DW-1:0]     cmd_wdata_q, cmd_wdata_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic req_ready, push, pop, in_issue, in_resp;

    // Ready looks only at the count, so a same-cycle pop never lets a full FIFO accept.
    assign req_ready = (count_q < DEPTH_C);
    assign push      = bus.core_req_valid && req_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign in_issue  = (state_q == ISSUE);
    assign in_resp   = (state_q == RESP);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q]  <= bus.core_req_addr;
            fifo_we[wr_ptr_q]    <= bus.core_req_we;
            fifo_wdata[wr_ptr_q] <= bus.core_req_wdata;
        end
    end

    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_we_d    = cmd_we_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cmd_addr_d  = fifo_addr[rd_ptr_q];
                    cmd_we_d    = fifo_we[rd_ptr_q];
                    cmd_wdata_d = fifo_wdata[rd_ptr_q];
                    tcnt_d      = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (bus.processor_resp) begin
                    rsp_rdata_d = cmd_we_q ? '0 : bus.mem_read_data;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if (tcnt_q == TLAST_C) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.core_rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            tcnt_q      <= '0;
            cmd_addr_q  <= '0;
            cmd_we_q    <= 1'b0;
            cmd_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_we_q    <= cmd_we_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus and response outputs are decoded from the state so they are zero outside their phase.
    assign bus.core_req_ready = req_ready;
    assign bus.processor_req  = in_issue;
    assign bus.mem_read_req   = in_issue && !cmd_we_q;
    assign bus.mem_write_req  = in_issue && cmd_we_q;
    assign bus.addr           = in_issue ? cmd_addr_q : '0;
    assign bus.mem_write_data = (in_issue && cmd_we_q) ? cmd_wdata_q : '0;
    assign bus.core_rsp_valid = in_resp;
    assign bus.core_rsp_we    = in_resp && cmd_we_q;
    assign bus.core_rsp_rdata = in_resp ? rsp_rdata_q : '0;
    assign bus.core_rsp_err   = in_resp && rsp_err_q;
    assign bus.busy           = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_requester.sv
// Directed bench for mem_port_requester: reset, load, store/load, FIFO full with timeout,
// response backpressure and mid-operation reset. Inputs change and outputs are sampled on negedge.
module tb_mem_port_requester;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_port_requester_if #(.DATA_SIZE(2), .ADDR_W(14)) bus ();

    mem_port_requester #(
        .DATA_SIZE(2), .ADDR_W(14), .FIFO_DEPTH(4), .TIMEOUT(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [13:0] a, input logic [15:0] d);
        bus.core_req_valid = 1'b1;
        bus.core_req_we    = we;
        bus.core_req_addr  = a;
        bus.core_req_wdata = d;
        @(negedge clk);
        bus.core_req_valid = 1'b0;
    endtask

    task automatic wait_req();
        int waited = 0;
        while (!bus.processor_req && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("wait_req_bound", bus.processor_req, 1);
    endtask

    // Called at the first negedge with processor_req high; response is sampled after hold more cycles.
    task automatic respond(input int hold, input logic [15:0] d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("req_held", bus.processor_req, 1);
        end
        bus.processor_resp = 1'b1;
        bus.mem_read_data  = d;
        @(negedge clk);
        bus.processor_resp = 1'b0;
        bus.mem_read_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int guard;
        int seen;

        reset = 1'b1;
        bus.core_req_valid = 1'b1;
        bus.core_req_we    = 1'b0;
        bus.core_req_addr  = 14'h0005;
        bus.core_req_wdata = '0;
        bus.core_rsp_ready = 1'b1;
        bus.processor_resp = 1'b0;
        bus.mem_read_data  = '0;

        // Reset for two edges while a command is offered.
        repeat (2) @(negedge clk);
        check("rst_req", bus.processor_req, 0);
        check("rst_rd", bus.mem_read_req, 0);
        check("rst_wr", bus.mem_write_req, 0);
        check("rst_ready", bus.core_req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_valid", bus.core_rsp_valid, 0);
        reset = 1'b0;
        bus.core_req_valid = 1'b0;
        @(negedge clk);
        check("rst_no_push", bus.busy, 0);

        // Single load; responder answers two cycles after the request appears.
        push(1'b0, 14'h0010, 16'h0000);
        check("load_latency_idle", bus.processor_req, 0);
        check("load_busy", bus.busy, 1);
        @(negedge clk);
        check("load_req", bus.processor_req, 1);
        check("load_rd", bus.mem_read_req, 1);
        check("load_wr", bus.mem_write_req, 0);
        check("load_addr", bus.addr, 14'h0010);
        check("load_wdata", bus.mem_write_data, 0);
        respond(2, 16'h0011);
        check("load_bus_low", bus.processor_req, 0);
        check("load_rd_low", bus.mem_read_req, 0);
        check("load_rsp_valid", bus.core_rsp_valid, 1);
        check("load_rsp_rdata", bus.core_rsp_rdata, 16'h0011);
        check("load_rsp_we", bus.core_rsp_we, 0);
        check("load_rsp_err", bus.core_rsp_err, 0);
        @(negedge clk);
        check("load_rsp_done", bus.core_rsp_valid, 0);
        check("load_idle", bus.busy, 0);

        // Store then load to the top address, pushed back-to-back.
        bus.core_req_valid = 1'b1;
        bus.core_req_we    = 1'b1;
        bus.core_req_addr  = 14'h3FFF;
        bus.core_req_wdata = 16'hBEEF;
        @(negedge clk);
        bus.core_req_we    = 1'b0;
        bus.core_req_wdata = 16'h0000;
        @(negedge clk);
        bus.core_req_valid = 1'b0;
        check("st_req", bus.processor_req, 1);
        check("st_wr", bus.mem_write_req, 1);
        check("st_rd", bus.mem_read_req, 0);
        check("st_addr", bus.addr, 14'h3FFF);
        check("st_wdata", bus.mem_write_data, 16'hBEEF);
        respond(0, 16'h1234);
        check("st_rsp_valid", bus.core_rsp_valid, 1);
        check("st_rsp_we", bus.core_rsp_we, 1);
        check("st_rsp_rdata", bus.core_rsp_rdata, 0);
        check("st_gap_resp", bus.processor_req, 0);
        @(negedge clk);
        check("st_gap_idle", bus.processor_req, 0);
        wait_req();
        check("ld2_rd", bus.mem_read_req, 1);
        check("ld2_wr", bus.mem_write_req, 0);
        check("ld2_addr", bus.addr, 14'h3FFF);
        check("ld2_wdata", bus.mem_write_data, 0);
        respond(0, 16'hBEEF);
        check("ld2_rsp_rdata", bus.core_rsp_rdata, 16'hBEEF);
        check("ld2_rsp_we", bus.core_rsp_we, 0);
        @(negedge clk);

        // Six back-to-back offers with no response: first issues, four fill the FIFO, sixth refused.
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            bus.core_req_valid = 1'b1;
            bus.core_req_we    = 1'b0;
            bus.core_req_addr  = 14'(14'h0100 + i);
            check($sformatf("full_ready_%0d", i), bus.core_req_ready, (i < 5) ? 1 : 0);
            if (bus.processor_req) hi++;
            @(negedge clk);
        end
        bus.core_req_valid = 1'b0;
        guard = 0;
        while (bus.processor_req && guard < 100) begin
            hi++;
            guard++;
            @(negedge clk);
        end
        check("to_req_cycles", hi, 32);
        check("to_rsp_valid", bus.core_rsp_valid, 1);
        check("to_rsp_err", bus.core_rsp_err, 1);
        check("to_rsp_rdata", bus.core_rsp_rdata, 0);
        check("to_ready_full", bus.core_req_ready, 0);
        @(negedge clk);
        check("full_ready_idle", bus.core_req_ready, 0);
        check("full_gap", bus.processor_req, 0);
        @(negedge clk);
        check("full_ready_pop", bus.core_req_ready, 1);
        check("order_addr_1", bus.addr, 14'h0101);
        respond(0, 16'h0101 ^ 16'hA5A5);
        check("order_rdata_1", bus.core_rsp_rdata, 16'h0101 ^ 16'hA5A5);
        check("order_err_1", bus.core_rsp_err, 0);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            wait_req();
            check($sformatf("order_addr_%0d", i), bus.addr, 14'h0100 + i);
            respond(0, 16'(16'hA5A5 ^ (16'h0100 + i)));
            check($sformatf("order_rdata_%0d", i), bus.core_rsp_rdata, 16'(16'hA5A5 ^ (16'h0100 + i)));
        end
        repeat (2) @(negedge clk);
        check("full_sixth_dropped", bus.busy, 0);

        // Response backpressure: fields hold while the FIFO keeps accepting.
        bus.core_rsp_ready = 1'b0;
        push(1'b1, 14'h0042, 16'h1357);
        wait_req();
        respond(0, 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            bus.core_req_valid = (i == 0);
            bus.core_req_we    = 1'b0;
            bus.core_req_addr  = 14'h0043;
            check("bp_valid", bus.core_rsp_valid, 1);
            check("bp_we", bus.core_rsp_we, 1);
            check("bp_rdata", bus.core_rsp_rdata, 0);
            check("bp_err", bus.core_rsp_err, 0);
            check("bp_bus", bus.processor_req, 0);
            @(negedge clk);
        end
        bus.core_req_valid = 1'b0;
        check("bp_ready", bus.core_req_ready, 1);
        bus.core_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", bus.core_rsp_valid, 0);
        wait_req();
        check("bp_next_addr", bus.addr, 14'h0043);

        // Reset during ISSUE drops the command with no completion.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_req", bus.processor_req, 0);
        check("mid_rst_rd", bus.mem_read_req, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.core_req_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.core_rsp_valid || bus.processor_req) seen++;
            @(negedge clk);
        end
        check("mid_rst_no_rsp", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
